// File: rtl/rf_write_scheduler.sv
// Arbitrates the single register-file write port between the WB stage and a
// one-entry buffer of long-latency results, and tracks pending destinations.
module rf_write_scheduler #(
  parameter int AGE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic [4:0]  id_rd_addr,
  output logic        id_stall,
  output logic        pipe_hold,
  output logic        rf_wr_en,
  output logic [4:0]  rf_wr_addr,
  output logic [31:0] rf_wr_data,
  output logic        err
);

  localparam int AGE_W = (AGE_MAX > 1) ? $clog2(AGE_MAX) : 1;
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(AGE_MAX - 1);

  typedef enum logic [1:0] {EMPTY, WAIT, FORCE} state_t;

  state_t            state, next_state;
  logic [AGE_W-1:0]  age, next_age;
  logic [4:0]        buf_rd;
  logic [31:0]       buf_data;
  logic [31:0]       busy, next_busy;
  logic              wb_req, drain, capture, err_hit;

  assign wb_req    = wb_valid && (wb_rd != 5'd0);
  assign lu_ready  = (state == EMPTY);
  assign pipe_hold = (state == FORCE);
  assign drain     = (state != EMPTY) && !wb_req;
  // Results for x0 are acknowledged but never occupy the buffer.
  assign capture   = lu_valid && lu_ready && (lu_rd != 5'd0);
  assign id_stall  = busy[id_rs1_addr] | busy[id_rs2_addr] | busy[id_rd_addr];

  assign err_hit = (wb_req && busy[wb_rd])
                || (lu_valid && (lu_rd != 5'd0) && !busy[lu_rd])
                || (issue_valid && (issue_rd != 5'd0) && busy[issue_rd]);

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    next_age   = age;
    case (state)
      EMPTY: begin
        if (capture) begin
          next_state = WAIT;
          next_age   = '0;
        end
      end
      WAIT: begin
        if (!wb_req) begin
          next_state = EMPTY;
          next_age   = '0;
        end else if (age == AGE_LAST) begin
          next_state = FORCE;
        end else begin
          next_age = age + 1'b1;
        end
      end
      FORCE: begin
        if (!wb_req) begin
          next_state = EMPTY;
          next_age   = '0;
        end
      end
      default: begin
        next_state = EMPTY;
        next_age   = '0;
      end
    endcase
  end

  // Clear is applied before set so a same-edge reissue keeps the bit busy.
  always_comb begin
    next_busy = busy;
    if (drain)
      next_busy[buf_rd] = 1'b0;
    if (issue_valid)
      next_busy[issue_rd] = 1'b1;
    next_busy[0] = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      age        <= '0;
      buf_rd     <= '0;
      buf_data   <= '0;
      busy       <= '0;
      err        <= 1'b0;
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
    end else begin
      state <= next_state;
      age   <= next_age;
      busy  <= next_busy;
      if (err_hit)
        err <= 1'b1;
      if (capture) begin
        buf_rd   <= lu_rd;
        buf_data <= lu_data;
      end
      if (wb_req) begin
        rf_wr_en   <= 1'b1;
        rf_wr_addr <= wb_rd;
        rf_wr_data <= wb_data;
      end else if (drain) begin
        rf_wr_en   <= 1'b1;
        rf_wr_addr <= buf_rd;
        rf_wr_data <= buf_data;
      end else begin
        rf_wr_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed bench for rf_write_scheduler: a transaction-level model is compared
// every cycle, plus literal expectations for each scenario.
module tb_rf_write_scheduler;

  localparam int AGE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, lu_valid, issue_valid;
  logic [4:0]  wb_rd, lu_rd, issue_rd;
  logic [31:0] wb_data, lu_data;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        lu_ready, id_stall, pipe_hold, rf_wr_en, err;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;

  int n_cmp = 0;
  int n_bad = 0;

  rf_write_scheduler #(.AGE_MAX(AGE_MAX)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_stall(id_stall), .pipe_hold(pipe_hold),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a held result plus a count of cycles it lost.
  logic [31:0] m_busy    = '0;
  bit          m_held    = 1'b0;
  logic [4:0]  m_rd      = '0;
  logic [31:0] m_data    = '0;
  int          m_blocked = 0;
  bit          m_wen     = 1'b0;
  logic [4:0]  m_waddr   = '0;
  logic [31:0] m_wdata   = '0;
  bit          m_err     = 1'b0;

  task automatic model_step();
    logic [31:0] nb;
    bit wbreq, was_held;
    if (rst) begin
      m_busy = '0; m_held = 0; m_blocked = 0; m_wen = 0; m_err = 0;
    end else begin
      wbreq    = wb_valid && (wb_rd != 5'd0);
      was_held = m_held;
      nb       = m_busy;
      if (wbreq && m_busy[wb_rd]) m_err = 1;
      if (lu_valid && lu_rd != 5'd0 && !m_busy[lu_rd]) m_err = 1;
      if (issue_valid && issue_rd != 5'd0 && m_busy[issue_rd]) m_err = 1;
      if (wbreq) begin
        m_wen = 1; m_waddr = wb_rd; m_wdata = wb_data;
        if (m_held) m_blocked++;
      end else if (m_held) begin
        m_wen = 1; m_waddr = m_rd; m_wdata = m_data;
        nb[m_rd] = 1'b0;
        m_held = 0; m_blocked = 0;
      end else begin
        m_wen = 0;
      end
      if (!was_held && lu_valid && lu_rd != 5'd0) begin
        m_held = 1; m_rd = lu_rd; m_data = lu_data; m_blocked = 0;
      end
      if (issue_valid && issue_rd != 5'd0) nb[issue_rd] = 1'b1;
      m_busy = nb;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    check("m_lu_ready", lu_ready, !m_held);
    check("m_pipe_hold", pipe_hold, m_held && (m_blocked >= AGE_MAX));
    check("m_id_stall", id_stall,
          m_busy[id_rs1_addr] | m_busy[id_rs2_addr] | m_busy[id_rd_addr]);
    check("m_wr_en", rf_wr_en, m_wen);
    if (m_wen) begin
      check("m_wr_addr", rf_wr_addr, m_waddr);
      check("m_wr_data", rf_wr_data, m_wdata);
    end
    check("m_err", err, m_err);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    lu_valid = 0; lu_rd = 0; lu_data = 0;
    issue_valid = 0; issue_rd = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
    #1;
    check("rst_wr_en", rf_wr_en, 0);
    check("rst_wr_addr", rf_wr_addr, 0);
    check("rst_wr_data", rf_wr_data, 0);
    check("rst_lu_ready", lu_ready, 1);
    check("rst_pipe_hold", pipe_hold, 0);
    check("rst_err", err, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Issue, return, drain of a single long-latency result.
    id_rs1_addr = 5'd5;
    issue_valid = 1; issue_rd = 5'd5;
    tick();
    check("t35_stall_set", id_stall, 1);
    issue_valid = 0;
    lu_valid = 1; lu_rd = 5'd5; lu_data = 32'hDEADBEEF;
    check("t35_ready_pre", lu_ready, 1);
    tick();
    check("t35_ready_held", lu_ready, 0);
    lu_valid = 0;
    tick();
    check("t35_wr_en", rf_wr_en, 1);
    check("t35_wr_addr", rf_wr_addr, 5);
    check("t35_wr_data", rf_wr_data, 32'hDEADBEEF);
    check("t35_stall_clr", id_stall, 0);
    tick();
    check("t35_wr_idle", rf_wr_en, 0);

    // WB wins over the held entry; entry drains on the next free cycle.
    issue_valid = 1; issue_rd = 5'd7;
    tick();
    issue_valid = 0;
    lu_valid = 1; lu_rd = 5'd7; lu_data = 32'h77;
    tick();
    lu_valid = 0;
    wb_valid = 1; wb_rd = 5'd3; wb_data = 32'h11;
    tick();
    check("t36_wb_addr", rf_wr_addr, 3);
    check("t36_wb_data", rf_wr_data, 32'h11);
    check("t36_ready", lu_ready, 0);
    wb_valid = 0;
    tick();
    check("t36_buf_en", rf_wr_en, 1);
    check("t36_buf_addr", rf_wr_addr, 7);
    check("t36_buf_data", rf_wr_data, 32'h77);

    // Starvation: AGE_MAX blocked cycles force a pipeline hold.
    issue_valid = 1; issue_rd = 5'd10;
    tick();
    issue_valid = 0;
    lu_valid = 1; lu_rd = 5'd10; lu_data = 32'hA5A5;
    tick();
    lu_valid = 0;
    wb_valid = 1; wb_rd = 5'd4; wb_data = 32'h44;
    for (int i = 1; i <= AGE_MAX; i++) begin
      tick();
      check($sformatf("t37_hold_%0d", i), pipe_hold, (i == AGE_MAX));
    end
    tick();
    check("t37_force_wb", rf_wr_addr, 4);
    check("t37_force_hold", pipe_hold, 1);
    wb_valid = 0;
    tick();
    check("t37_drain_addr", rf_wr_addr, 10);
    check("t37_drain_data", rf_wr_data, 32'hA5A5);
    check("t37_hold_off", pipe_hold, 0);

    // x0 traffic is accepted and dropped.
    lu_valid = 1; lu_rd = 5'd0; lu_data = 32'h55;
    tick();
    check("t38_lu_ready", lu_ready, 1);
    check("t38_lu_no_wr", rf_wr_en, 0);
    check("t38_err", err, 0);
    lu_valid = 0;
    wb_valid = 1; wb_rd = 5'd0; wb_data = 32'h99;
    tick();
    check("t38_wb_no_wr", rf_wr_en, 0);
    wb_valid = 0;

    // Protocol error on WB to busy register; sticky.
    issue_valid = 1; issue_rd = 5'd9;
    tick();
    issue_valid = 0;
    wb_valid = 1; wb_rd = 5'd9; wb_data = 32'h1;
    tick();
    check("t39_err_set", err, 1);
    wb_valid = 0;
    tick(); tick();
    check("t39_err_sticky", err, 1);

    // Reissue on the edge that drains the same register keeps it busy.
    id_rs1_addr = 5'd12;
    issue_valid = 1; issue_rd = 5'd12;
    tick();
    issue_valid = 0;
    lu_valid = 1; lu_rd = 5'd12; lu_data = 32'hC0C0;
    tick();
    lu_valid = 0;
    issue_valid = 1; issue_rd = 5'd12;
    tick();
    issue_valid = 0;
    check("t39_drain_addr", rf_wr_addr, 12);
    check("t39_set_wins", id_stall, 1);

    // Asynchronous reset mid-cycle with an entry held.
    id_rs1_addr = 5'd14;
    tick();
    issue_valid = 1; issue_rd = 5'd14;
    tick();
    issue_valid = 0;
    lu_valid = 1; lu_rd = 5'd14; lu_data = 32'hE14E;
    tick();
    lu_valid = 0;
    check("t40_held", lu_ready, 0);
    #2 rst = 1'b1;
    #1;
    check("t40_rst_wr_en", rf_wr_en, 0);
    check("t40_rst_wr_addr", rf_wr_addr, 0);
    check("t40_rst_err", err, 0);
    check("t40_rst_ready", lu_ready, 1);
    check("t40_rst_stall", id_stall, 0);
    check("t40_rst_hold", pipe_hold, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t40_no_wr_%0d", i), rf_wr_en, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rf_write_scheduler.md
RF_WRITE_SCHEDULER -- requirements
Module: rf_write_scheduler

Interface
REQ-001 Parameter AGE_MAX, default 4: maximum consecutive cycles a held long-latency result may lose arbitration before pipeline hold is forced.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 wb_valid  input  1  pipeline WB stage requests a register write this cycle.
REQ-005 wb_rd  input  5  WB destination register.
REQ-006 wb_data  input  32  WB write data.
REQ-007 lu_valid  input  1  long-latency unit (mul/div/load-miss) result valid.
REQ-008 lu_rd  input  5  long-latency result destination register.
REQ-009 lu_data  input  32  long-latency result data.
REQ-010 lu_ready  output  1  scheduler accepts the long-latency result this cycle.
REQ-011 issue_valid  input  1  long-latency op issued this cycle; marks issue_rd pending.
REQ-012 issue_rd  input  5  destination of the issued long-latency op.
REQ-013 id_rs1_addr, id_rs2_addr, id_rd_addr  input  5 each  ID-stage operand and destination registers.
REQ-014 id_stall  output  1  ID instruction touches a pending register.
REQ-015 pipe_hold  output  1  freeze the pipeline so WB presents no write next cycle.
REQ-016 rf_wr_en, rf_wr_addr, rf_wr_data  output  1/5/32  register file write port.
REQ-017 err  output  1  sticky protocol error flag.

Function
REQ-018 Write-port outputs SHALL be registered: values chosen at edge N appear after edge N, 1-cycle latency from request.
REQ-019 Priority at each edge: WB write (wb_valid, wb_rd!=0) > held buffer entry > none (rf_wr_en=0).
REQ-020 Writes to x0 SHALL never drive rf_wr_en=1; wb_rd==0 counts as no WB request.
REQ-021 One-entry holding buffer; lu_ready=1 only when buffer empty (no same-cycle bypass to write port).
REQ-022 Handshake: entry captured on edge with lu_valid&&lu_ready; lu_rd==0 result accepted and discarded (buffer stays empty).
REQ-023 FSM states EMPTY, WAIT, FORCE; reset to EMPTY.
REQ-024 EMPTY -> WAIT on capture with lu_rd!=0; else stay.
REQ-025 WAIT: if no WB request, entry written, -> EMPTY; else age counter +1; when age reaches AGE_MAX-1 while blocked -> FORCE.
REQ-026 FORCE: pipe_hold=1 (decoded from state only); entry written on first cycle with no WB request, -> EMPTY; a WB request in FORCE still wins, stay FORCE.
REQ-027 Age counter clears on entry to EMPTY; saturates, never wraps.
REQ-028 Scoreboard: 32-bit busy vector; bit[issue_rd] set on edge with issue_valid and issue_rd!=0; bit cleared on edge the buffer entry for that rd is written to the write port.
REQ-029 Same-edge set and clear of the same bit: set wins; different bits: both take effect.
REQ-030 busy[0] SHALL always read 0.
REQ-031 id_stall combinational = busy[id_rs1_addr] | busy[id_rs2_addr] | busy[id_rd_addr].
REQ-032 err set (sticky until reset) when: WB request targets a busy register; lu_valid with lu_rd not busy and !=0; issue_valid to an already-busy register.

Reset
REQ-033 On rst assertion, immediately: FSM EMPTY, buffer empty, age 0, busy all 0, rf_wr_en 0, rf_wr_addr 0, rf_wr_data 0, err 0; lu_ready=1, pipe_hold=0, id_stall=0.
REQ-034 Reset mid-operation discards any held entry without writing it.

Verification
REQ-035 issue_valid rd=5; next cycle lu_valid rd=5 data 0xDEADBEEF, no WB -> capture, next edge rf_wr_en=1 addr 5 data 0xDEADBEEF, busy[5] clears, id_stall for rs1=5 drops.
REQ-036 Buffer held (rd=7), WB valid rd=3 data 0x11 same cycle -> WB written first; rd=7 written the following free cycle; lu_ready=0 throughout hold.
REQ-037 Buffer held, WB requests every cycle for 4 cycles (AGE_MAX=4) -> pipe_hold=1 from 5th cycle; first WB-free cycle writes entry, pipe_hold=0 next cycle.
REQ-038 lu_valid rd=0 data 0x55 -> lu_ready stays 1, rf_wr_en never 1, err stays 0; WB rd=0 likewise no write.
REQ-039 WB rd=9 while busy[9]=1 -> err=1, stays 1 until rst; issue and clear same register on one edge -> busy remains 1.
REQ-040 rst asserted between clock edges with entry held -> outputs reset immediately; no write of held entry after release.
